alarm_key_entry: RTL

//  Keypad front end that writes the alarm register and the clock preset: shifts

---
 rtl/alarm_key_entry_if.sv | 30 +++
 rtl/alarm_key_entry.sv | 137 +++++++++++++
 2 files changed

// File: rtl/alarm_key_entry_if.sv
// Keypad-side bundle for alarm_key_entry: key/button/tick inputs and buffer/strobe outputs.
// The master drives the keypad and buttons; the slave is the entry controller.
interface alarm_key_entry_if;
   logic       one_second;
   logic       key_valid;
   logic [3:0] key;
   logic       alarm_button;
   logic       time_button;
   logic [3:0] new_alarm_ms_hr;
   logic [3:0] new_alarm_ls_hr;
   logic [3:0] new_alarm_ms_min;
   logic [3:0] new_alarm_ls_min;
   logic       load_new_a;
   logic       load_new_c;
   logic       show_new_time;
   logic       show_a;
   logic       entry_error;

   modport master (
      output one_second, key_valid, key, alarm_button, time_button,
      input  new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min,
      input  load_new_a, load_new_c, show_new_time, show_a, entry_error
   );

   modport slave (
      input  one_second, key_valid, key, alarm_button, time_button,
      output new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min,
      output load_new_a, load_new_c, show_new_time, show_a, entry_error
   );
endinterface

// File: rtl/alarm_key_entry.sv
// Keypad entry controller: shifts digits into an HH:MM buffer, validates it and commits it
// to the alarm register or clock preset on a button edge; abandons entry after a timeout.
module alarm_key_entry #(
   parameter int unsigned TIMEOUT_S = 10
) (
   input logic               clk,
   input logic               reset,
   alarm_key_entry_if.slave  kp
);
   localparam int unsigned TimerW = $clog2(TIMEOUT_S + 1);
   localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_S - 1);
   localparam logic [TimerW-1:0] TimerMax  = {TimerW{1'b1}};

   typedef enum logic [1:0] {StIdle, StShowAlarm, StEntry} state_e;

   state_e            state;
   logic [TimerW-1:0] timer;
   logic              alarm_q;
   logic              time_q;
   logic [3:0]        ms_hr;
   logic [3:0]        ls_hr;
   logic [3:0]        ms_min;
   logic [3:0]        ls_min;
   logic              load_a;
   logic              load_c;
   logic              error;
   logic              show_new;
   logic              show_alarm;

   logic alarm_edge;
   logic time_edge;
   logic digit;
   logic buf_valid;

   assign alarm_edge = kp.alarm_button & ~alarm_q;
   assign time_edge  = kp.time_button & ~time_q;
   assign digit      = kp.key_valid & (kp.key <= 4'd9);

   // Hours may reach 23 only: units limited to 3 once the tens digit is 2.
   assign buf_valid = (ms_hr <= 4'd2) &&
                      (ls_hr <= ((ms_hr == 4'd2) ? 4'd3 : 4'd9)) &&
                      (ms_min <= 4'd5) &&
                      (ls_min <= 4'd9);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= StIdle;
         timer      <= '0;
         alarm_q    <= 1'b0;
         time_q     <= 1'b0;
         ms_hr      <= 4'd0;
         ls_hr      <= 4'd0;
         ms_min     <= 4'd0;
         ls_min     <= 4'd0;
         load_a     <= 1'b0;
         load_c     <= 1'b0;
         error      <= 1'b0;
         show_new   <= 1'b0;
         show_alarm <= 1'b0;
      end else begin
         alarm_q <= kp.alarm_button;
         time_q  <= kp.time_button;
         load_a  <= 1'b0;
         load_c  <= 1'b0;
         error   <= 1'b0;
         unique case (state)
            StIdle: begin
               show_new   <= 1'b0;
               show_alarm <= 1'b0;
               if (digit) begin
                  {ms_hr, ls_hr, ms_min} <= 12'h000;
                  ls_min   <= kp.key;
                  timer    <= '0;
                  show_new <= 1'b1;
                  state    <= StEntry;
               end else if (alarm_edge) begin
                  show_alarm <= 1'b1;
                  state      <= StShowAlarm;
               end
            end
            StShowAlarm: begin
               if (kp.alarm_button) begin
                  show_alarm <= 1'b1;
               end else begin
                  show_alarm <= 1'b0;
                  state      <= StIdle;
               end
            end
            StEntry: begin
               if (alarm_edge && time_edge) begin
                  // Ambiguous commit: stay put and let the user try again.
                  timer <= '0;
               end else if (alarm_edge || time_edge) begin
                  timer    <= '0;
                  show_new <= 1'b0;
                  state    <= StIdle;
                  if (buf_valid) begin
                     load_a <= alarm_edge;
                     load_c <= time_edge;
                  end else begin
                     error                           <= 1'b1;
                     {ms_hr, ls_hr, ms_min, ls_min} <= 16'h0000;
                  end
               end else if (digit) begin
                  ms_hr  <= ls_hr;
                  ls_hr  <= ms_min;
                  ms_min <= ls_min;
                  ls_min <= kp.key;
                  timer  <= '0;
               end else if (kp.one_second) begin
                  if (timer == TimerLast) begin
                     {ms_hr, ls_hr, ms_min, ls_min} <= 16'h0000;
                     timer    <= '0;
                     show_new <= 1'b0;
                     state    <= StIdle;
                  end else if (timer != TimerMax) begin
                     timer <= timer + 1'b1;
                  end
               end
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

   assign kp.new_alarm_ms_hr  = ms_hr;
   assign kp.new_alarm_ls_hr  = ls_hr;
   assign kp.new_alarm_ms_min = ms_min;
   assign kp.new_alarm_ls_min = ls_min;
   assign kp.load_new_a       = load_a;
   assign kp.load_new_c       = load_c;
   assign kp.entry_error      = error;
   assign kp.show_new_time    = show_new;
   assign kp.show_a           = show_alarm;
endmodule
